// File: rtl/instr_mem_fetch.sv
// Instruction memory with a synchronous program-load port and a one-entry
// registered fetch response guarded by a valid/ready handshake.
module instr_mem_fetch #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DEPTH    = 16,
  parameter bit          INIT_IDX = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              wr_in_range;
  logic              req_in_range;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_range  = 32'(wr_addr)  < DEPTH;
  assign req_in_range = 32'(req_addr) < DEPTH;

  assign resp_valid = (state == FULL);
  assign req_ready  = !resp_valid || resp_ready;
  assign accept     = req_valid && req_ready;

  // Same-cycle write to the fetched address is forwarded (write-first).
  always_comb begin
    rd_word = '0;
    if (req_in_range) begin
      if (wr_en && wr_in_range && (wr_addr == req_addr))
        rd_word = wr_data;
      else
        rd_word = mem[req_addr];
    end
  end

  // NOTE: the array is built from flops, not a RAM macro, because a reset
  // reload of the whole program image is part of the block's behaviour.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= INIT_IDX ? DATA_W'(i) : '0;
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= EMPTY;
      resp_data <= '0;
      resp_addr <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            resp_data <= rd_word;
            resp_addr <= req_addr;
            resp_err  <= !req_in_range;
          end
        end
        FULL: begin
          if (accept) begin
            resp_data <= rd_word;
            resp_addr <= req_addr;
            resp_err  <= !req_in_range;
          end else if (resp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: default instance plus a DEPTH=12
// instance sharing the same stimulus for out-of-range behaviour.
module tb_instr_mem_fetch;

  logic        clk = 1'b0;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req_valid;
  logic [3:0]  req_addr;
  logic        resp_ready;

  logic        req_ready,  resp_valid,  resp_err;
  logic [15:0] resp_data;
  logic [3:0]  resp_addr;
  logic        req_ready12, resp_valid12, resp_err12;
  logic [15:0] resp_data12;
  logic [3:0]  resp_addr12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_fetch u_dut (
    .clk(clk), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err)
  );

  instr_mem_fetch #(.DEPTH(12)) u_dut12 (
    .clk(clk), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready12), .req_addr(req_addr),
    .resp_valid(resp_valid12), .resp_ready(resp_ready),
    .resp_data(resp_data12), .resp_addr(resp_addr12), .resp_err(resp_err12)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_data",  32'(resp_data),  32'h0);
    check("rst_err",   32'(resp_err),   32'h0);
    clr = 1'b1;
    tick();

    // 1: back-to-back fetches of the index-filled image
    req_valid = 1'b1; req_addr = 4'd0;
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    tick(); check("t1_d0", 32'(resp_data), 32'h0000); check("t1_v0", 32'(resp_valid), 32'h1);
    req_addr = 4'd1;
    tick(); check("t1_d1", 32'(resp_data), 32'h0001); check("t1_a1", 32'(resp_addr), 32'h1);
    req_addr = 4'd2;
    tick(); check("t1_d2", 32'(resp_data), 32'h0002); check("t1_err", 32'(resp_err), 32'h0);
    req_valid = 1'b0;
    tick(); check("t1_drain", 32'(resp_valid), 32'h0);

    // 2: program-load write then fetch
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; req_valid = 1'b1; req_addr = 4'd5;
    tick(); check("t2_data", 32'(resp_data), 32'hBEEF); check("t2_addr", 32'(resp_addr), 32'h5);
    req_valid = 1'b0;
    tick();

    // 3: write-first forwarding, then the stored value
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; req_valid = 1'b1; req_addr = 4'd3;
    tick(); check("t3_fwd", 32'(resp_data), 32'h1234);
    wr_en = 1'b0;
    tick(); check("t3_mem", 32'(resp_data), 32'h1234);
    req_valid = 1'b0;
    tick();

    // 4: back-pressure holds the response and blocks acceptance
    req_valid = 1'b1; req_addr = 4'd7;
    tick(); check("t4_d7", 32'(resp_data), 32'h0007);
    req_addr = 4'd8; resp_ready = 1'b0;
    #1 check("t4_ready0", 32'(req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_data",  32'(resp_data),  32'h0007);
      check("t4_hold_addr",  32'(resp_addr),  32'h7);
      check("t4_hold_valid", 32'(resp_valid), 32'h1);
      check("t4_hold_ready", 32'(req_ready),  32'h0);
    end
    resp_ready = 1'b1;
    #1 check("t4_ready1", 32'(req_ready), 32'h1);
    tick(); check("t4_d8", 32'(resp_data), 32'h0008);
    req_addr = 4'd13;
    tick(); check("t4_d13", 32'(resp_data), 32'h000D); check("t4_err13", 32'(resp_err), 32'h0);
    req_valid = 1'b0;
    tick();

    // 6: asynchronous reset mid-stall; writes during reset are ignored
    req_valid = 1'b1; req_addr = 4'd5; resp_ready = 1'b0;
    tick(); check("t6_pre", 32'(resp_data), 32'hBEEF); check("t6_pre_v", 32'(resp_valid), 32'h1);
    #2 clr = 1'b0;
    #1 check("t6_async_v", 32'(resp_valid), 32'h0); check("t6_async_d", 32'(resp_data), 32'h0);
    req_valid = 1'b0; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'hAAAA;
    tick();
    wr_en = 1'b0; resp_ready = 1'b1;
    @(negedge clk) clr = 1'b1;
    req_valid = 1'b1; req_addr = 4'd5;
    tick(); check("t6_d5", 32'(resp_data), 32'h0005);
    req_addr = 4'd6;
    tick(); check("t6_d6", 32'(resp_data), 32'h0006);
    req_valid = 1'b0;
    tick();

    // 5: DEPTH=12 instance, out-of-range fetches and dropped writes
    req_valid = 1'b1; req_addr = 4'd13;
    tick(); check("t5_err13", 32'(resp_err12), 32'h1); check("t5_d13", 32'(resp_data12), 32'h0);
    check("t5_a13", 32'(resp_addr12), 32'hD);
    req_valid = 1'b0; wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'h5A5A;
    tick();
    wr_en = 1'b0; req_valid = 1'b1; req_addr = 4'd12;
    tick(); check("t5_err12", 32'(resp_err12), 32'h1); check("t5_d12", 32'(resp_data12), 32'h0);
    req_addr = 4'd11;
    tick(); check("t5_err11", 32'(resp_err12), 32'h0); check("t5_d11", 32'(resp_data12), 32'h000B);
    req_addr = 4'd1;
    tick(); check("t5_d1", 32'(resp_data12), 32'h0001);
    req_valid = 1'b0;
    tick(); check("t5_drain", 32'(resp_valid12), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
